// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversampling ratio and
// majority-vote tap positions, common to the receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    // Vote taps sit at mid-bit -1, mid-bit and mid-bit +1.
    localparam int unsigned VOTE_OFS_EARLY = 1;
    localparam int unsigned VOTE_OFS_LATE  = 1;

    // Tick index of vote tap idx (0 = earliest, 2 = resolving tap).
    function automatic int unsigned vote_tap(input int unsigned os, input int unsigned idx);
        return os / 2 - VOTE_OFS_EARLY + idx;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-FF synchroniser for the raw line plus a 3-tap majority voter
// around the bit centre. bit_val is valid on the tick where t_cnt hits the last tap.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    localparam int unsigned TW = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic          b_tick,
    input  logic [TW-1:0] t_cnt,
    output logic          rx_s,
    output logic          bit_val
);

    localparam logic [TW-1:0] TAP0 = TW'(vote_tap(OVERSAMPLE, 0));
    localparam logic [TW-1:0] TAP1 = TW'(vote_tap(OVERSAMPLE, 1));

    logic sync1_q, sync2_q;
    logic tap0_q, tap1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tap0_q  <= 1'b1;
            tap1_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            if (b_tick && t_cnt == TAP0) tap0_q <= sync2_q;
            if (b_tick && t_cnt == TAP1) tap1_q <= sync2_q;
        end
    end

    assign rx_s = sync2_q;

    // Third tap is the live synchronised value on the resolving tick.
    assign bit_val = (tap0_q & tap1_q) | (tap0_q & sync2_q) | (tap1_q & sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, tick/bit counters and output registers
// on top of the synchronising, majority-voting sampler.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 b_tick,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rx_done,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_VOTE = TW'(vote_tap(OVERSAMPLE, 2));
    localparam logic [3:0] N_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] N_STOP_LAST = 4'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        t_cnt_q, t_cnt_d;
    logic [3:0]           n_q, n_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 fe_q, fe_d;
    logic                 stops_low_q, stops_low_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 rx_s, bit_val;
    logic                 fe_now, brk_now;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .b_tick (b_tick),
        .t_cnt  (t_cnt_q),
        .rx_s   (rx_s),
        .bit_val(bit_val)
    );

    // Final-stop-bit view of the frame, used only on the completing tick.
    assign fe_now  = fe_q | ~bit_val;
    assign brk_now = (shreg_q == '0) && !par_bit_q && stops_low_q && !bit_val;

    always_comb begin
        state_d     = state_q;
        t_cnt_d     = t_cnt_q;
        n_d         = n_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        fe_d        = fe_q;
        stops_low_d = stops_low_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        brk_d       = brk_q;

        if (b_tick) begin
            t_cnt_d = t_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    t_cnt_d = '0;
                    if (!rx_s) begin
                        state_d     = START;
                        t_cnt_d     = TW'(1);
                        n_d         = '0;
                        fe_d        = 1'b0;
                        stops_low_d = 1'b1;
                        par_bit_d   = 1'b0;
                        par_err_d   = 1'b0;
                    end
                end
                START: begin
                    if (t_cnt_q == T_VOTE && bit_val) begin
                        state_d = IDLE;
                        t_cnt_d = '0;
                    end else if (t_cnt_q == T_LAST) begin
                        state_d = DATA;
                        t_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (t_cnt_q == T_VOTE) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
                    if (t_cnt_q == T_LAST) begin
                        t_cnt_d = '0;
                        if (n_q == N_DATA_LAST) begin
                            n_d     = '0;
                            state_d = PARITY_EN ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (t_cnt_q == T_VOTE) begin
                        par_bit_d = bit_val;
                        par_err_d = ((^shreg_q) ^ bit_val) != PARITY_ODD;
                    end
                    if (t_cnt_q == T_LAST) begin
                        t_cnt_d = '0;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (t_cnt_q == T_VOTE) begin
                        fe_d        = fe_now;
                        stops_low_d = stops_low_q & ~bit_val;
                        if (n_q == N_STOP_LAST) begin
                            dout_d  = shreg_q;
                            perr_d  = PARITY_EN & par_err_q;
                            ferr_d  = fe_now;
                            brk_d   = brk_now;
                            done_d  = 1'b1;
                            t_cnt_d = '0;
                            n_d     = '0;
                            state_d = brk_now ? BREAK_WAIT : IDLE;
                        end
                    end else if (t_cnt_q == T_LAST) begin
                        t_cnt_d = '0;
                        n_d     = n_q + 4'd1;
                    end
                end
                BREAK_WAIT: begin
                    t_cnt_d = '0;
                    if (rx_s) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    t_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            t_cnt_q     <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            fe_q        <= 1'b0;
            stops_low_q <= 1'b0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_cnt_q     <= t_cnt_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            fe_q        <= fe_d;
            stops_low_q <= stops_low_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
        end
    end

    assign o_dout       = dout_q;
    assign o_rx_done    = done_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7E2 instance driven
// from one clock and a b_tick at half the clock rate.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLKS = 2 * OS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       b_tick = 1'b0;
    logic       tick_en = 1'b1;
    logic       rx1 = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] dout1;
    logic [6:0] dout2;
    logic       done1, perr1, ferr1, brk1;
    logic       done2, perr2, ferr2, brk2;

    int n_checks = 0;
    int n_err    = 0;
    int n_done1  = 0;
    int n_done2  = 0;
    int n_dbl    = 0;
    logic prev1  = 1'b0;
    logic prev2  = 1'b0;

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .b_tick(b_tick), .o_dout(dout1),
        .o_rx_done(done1), .o_parity_err(perr1), .o_frame_err(ferr1), .o_break(brk1)
    );

    uart_rx_param #(
        .DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .b_tick(b_tick), .o_dout(dout2),
        .o_rx_done(done2), .o_parity_err(perr2), .o_frame_err(ferr2), .o_break(brk2)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 b_tick = tick_en ? ~b_tick : 1'b0;
    end

    always @(posedge clk) begin
        prev1 <= done1;
        prev2 <= done2;
        if (done1) n_done1 <= n_done1 + 1;
        if (done2) n_done2 <= n_done2 + 1;
        if ((done1 && prev1) || (done2 && prev2)) n_dbl <= n_dbl + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int line, input logic v);
        if (line == 0) rx1 = v;
        else rx2 = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_8n1(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(0, bits[i]);
    endtask

    task automatic send_7e2(input logic [6:0] d, input logic par);
        logic [10:0] bits;
        bits = {2'b11, par, d, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(1, bits[i]);
    endtask

    int exp1 = 0;

    initial begin
        wait_clks(5);
        chk("reset_dout", 32'(dout1), 32'h0);
        chk("reset_done", 32'(done1), 32'h0);
        chk("reset_perr", 32'(perr1), 32'h0);
        chk("reset_ferr", 32'(ferr1), 32'h0);
        chk("reset_brk", 32'(brk1), 32'h0);
        chk("reset_state", 32'(dut1.state_q), 32'(IDLE));
        reset = 1'b1;
        wait_clks(BIT_CLKS);

        // 8N1 back-to-back
        send_8n1(8'h55, 1'b1);
        exp1++;
        chk("b2b_dout0", 32'(dout1), 32'h55);
        chk("b2b_cnt0", 32'(n_done1), 32'(exp1));
        send_8n1(8'hA3, 1'b1);
        exp1++;
        chk("b2b_dout1", 32'(dout1), 32'hA3);
        chk("b2b_cnt1", 32'(n_done1), 32'(exp1));
        chk("b2b_flags", {29'd0, perr1, ferr1, brk1}, 32'h0);
        wait_clks(2 * BIT_CLKS);

        // 7E2 with wrong (odd) parity bit
        send_7e2(7'h41, 1'b1);
        chk("7e2_dout", 32'(dout2), 32'h41);
        chk("7e2_perr", 32'(perr2), 32'h1);
        chk("7e2_ferr", 32'(ferr2), 32'h0);
        chk("7e2_cnt", 32'(n_done2), 32'd1);

        // False start of 3 ticks
        rx1 = 1'b0;
        wait_clks(6);
        rx1 = 1'b1;
        wait_clks(3 * BIT_CLKS);
        chk("false_cnt", 32'(n_done1), 32'(exp1));
        chk("false_state", 32'(dut1.state_q), 32'(IDLE));
        send_8n1(8'h0F, 1'b1);
        exp1++;
        chk("after_false_dout", 32'(dout1), 32'h0F);
        chk("after_false_cnt", 32'(n_done1), 32'(exp1));

        // Stop bit low
        send_8n1(8'h3C, 1'b0);
        rx1 = 1'b1;
        wait_clks(3 * BIT_CLKS);
        exp1++;
        chk("ferr_dout", 32'(dout1), 32'h3C);
        chk("ferr_flag", 32'(ferr1), 32'h1);
        chk("ferr_brk", 32'(brk1), 32'h0);
        chk("ferr_cnt", 32'(n_done1), 32'(exp1));

        // 0x00 with a one-tick glitch in the middle of data bit 3
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
        rx1 = 1'b0;
        wait_clks(OS);
        rx1 = 1'b1;
        wait_clks(2);
        rx1 = 1'b0;
        wait_clks(BIT_CLKS - OS - 2);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        exp1++;
        chk("glitch_dout", 32'(dout1), 32'h00);
        chk("glitch_ferr", 32'(ferr1), 32'h0);
        chk("glitch_cnt", 32'(n_done1), 32'(exp1));

        // Break: line low for 20 bit-times
        rx1 = 1'b0;
        wait_clks(20 * BIT_CLKS);
        exp1++;
        chk("brk_cnt", 32'(n_done1), 32'(exp1));
        chk("brk_dout", 32'(dout1), 32'h00);
        chk("brk_flag", 32'(brk1), 32'h1);
        chk("brk_ferr", 32'(ferr1), 32'h1);
        rx1 = 1'b1;
        wait_clks(2 * BIT_CLKS);
        chk("brk_quiet_cnt", 32'(n_done1), 32'(exp1));
        send_8n1(8'h81, 1'b1);
        exp1++;
        chk("post_brk_dout", 32'(dout1), 32'h81);
        chk("post_brk_flags", {30'd0, ferr1, brk1}, 32'h0);
        chk("post_brk_cnt", 32'(n_done1), 32'(exp1));
        wait_clks(BIT_CLKS);

        // Reset during data bit 4 of 0xF0
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0);
        rx1 = 1'b1;
        wait_clks(OS / 2);
        reset = 1'b0;
        wait_clks(4);
        chk("rst_mid_dout", 32'(dout1), 32'h0);
        chk("rst_mid_done", 32'(done1), 32'h0);
        chk("rst_mid_dout2", 32'(dout2), 32'h0);
        chk("rst_mid_perr2", 32'(perr2), 32'h0);
        reset = 1'b1;
        wait_clks(BIT_CLKS * 5);
        chk("rst_mid_cnt", 32'(n_done1), 32'(exp1));
        send_8n1(8'h5A, 1'b1);
        exp1++;
        chk("post_rst_dout", 32'(dout1), 32'h5A);
        chk("post_rst_flags", {29'd0, perr1, ferr1, brk1}, 32'h0);
        chk("post_rst_cnt", 32'(n_done1), 32'(exp1));
        wait_clks(BIT_CLKS);

        chk("single_cycle_pulse", 32'(n_dbl), 32'd0);
        chk("dut2_total_cnt", 32'(n_done2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver, adding configurable frame format, input synchronisation, 3-sample majority voting, false-start rejection, and parity/framing/break reporting. It sits between the board RX pin and the RX FIFO and is driven by the shared baud-tick generator running at OVERSAMPLE × baud. Each received frame produces one `o_rx_done` pulse, and the FIFO push uses that pulse directly.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit; even, ≥ 8.
- `PARITY_EN`, default 0: 1 = parity bit present after the data bits.
- `PARITY_ODD`, default 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: raw serial line, asynchronous, idles high.
- `b_tick` in 1: one-`clk` pulse at OVERSAMPLE × baud.
- `o_dout` out `DATA_BITS`: received data, LSB-first on the wire, right-aligned.
- `o_rx_done` out 1: one-`clk` pulse per completed frame.
- `o_parity_err` out 1: parity mismatch on the last frame.
- `o_frame_err` out 1: a stop bit sampled low on the last frame.
- `o_break` out 1: last frame was all-zero, with parity and stop bits also low.

## Operation
- `rx` passes through a 2-FF synchroniser (`rx_s`). All decisions use `rx_s`.
- The tick counter `t_cnt` counts 0..OVERSAMPLE-1 per bit, advancing only on `b_tick`.
- Bit value is the majority of `rx_s` sampled at `t_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The vote resolves on the tick with `t_cnt` = OVERSAMPLE/2+1.
- **IDLE**: `t_cnt` = 0, bit counter = 0. On `b_tick` with `rx_s` = 0, go to START with `t_cnt` = 0 on that tick.
- **START**: at the vote point:
  - vote = 1 (false start): return to IDLE with no pulse and no flag change.
  - vote = 0: continue. At `t_cnt` = OVERSAMPLE-1, go to DATA.
- **DATA**: at each vote, shift the bit into `o_dout` MSB-side, so the first bit ends at bit 0. After DATA_BITS bits, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY**: at the vote, compute the error as XOR(data, parity bit) ≠ `PARITY_ODD`. Go to STOP after OVERSAMPLE ticks.
- **STOP**: sample each stop bit by vote. Any stop bit low sets the frame error.
  - Completion is taken at the vote point of the final stop bit, not its end, so resync margin is half a bit.
  - On completion, go to IDLE, or to BREAK_WAIT if a break is detected.
- **BREAK_WAIT**: stay until `rx_s` = 1 is seen on a `b_tick`, then go to IDLE. No new start is detected while in this state.
- On completion, `o_dout`, `o_parity_err`, `o_frame_err` and `o_break` update in the same cycle `o_rx_done` pulses. They hold until the next completion.
- `o_break` always implies `o_frame_err` = 1. `o_parity_err` is 0 when `PARITY_EN` = 0.

## Timing
- Reset values: all outputs 0, state IDLE, synchroniser flops 1, counters 0.
- Reset asserted mid-frame aborts immediately with no pulse. The first frame after release requires a fresh falling edge.
- Start latency: a falling edge on `rx` reaches `rx_s` after 2 `clk` cycles. It is detected on the next `b_tick`.
- `o_rx_done` is high for exactly one `clk` cycle, registered, on the cycle after the completing `b_tick`. It never stays high on consecutive cycles.
- Back-to-back frames: a start edge arriving during the second half of the last stop bit is detected on the first `b_tick` after the return to IDLE. No frame is dropped at 0 ppm.
- State changes occur only on `b_tick` cycles. With `b_tick` held low, all state and outputs freeze.

## Structure
- Shared package `uart_pkg`: state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT), default `OVERSAMPLE` and the vote offsets. The transmitter successor reuses these.
- One sub-module, `uart_rx_sampler`: contains the 2-FF synchroniser plus the 3-tap majority voter, with outputs `rx_s` and `bit_val`. The FSM, counters and output registers live in the top-level module.

## Test plan
- 8N1, send 0x55 then 0xA3 back-to-back → `o_dout` = 0x55 then 0xA3, two single-cycle `o_rx_done` pulses, all flags 0.
- 7E2 (`DATA_BITS` = 7, even parity, 2 stop bits), send 0x41 with parity bit 1 → `o_dout` = 0x41, `o_parity_err` = 1, `o_frame_err` = 0.
- `rx` low for 3 ticks then high → no `o_rx_done`, FSM back in IDLE. Then a valid frame 0x0F is received correctly.
- 8N1, 0x3C with the stop bit driven low → `o_frame_err` = 1, `o_break` = 0, `o_dout` = 0x3C.
- `rx` held low for 20 bit-times → exactly one `o_rx_done` with `o_dout` = 0, `o_break` = 1 and `o_frame_err` = 1. No further pulse until `rx` returns high and a new frame arrives.
- A 1-tick glitch at mid-bit 3 of 0x00 is rejected by the vote (`o_dout` = 0x00). Reset asserted during bit 4 of a later frame → outputs 0, no pulse, next frame clean.
